// File: rtl/add_pipe_n.sv
// ---------------------------------------------------------------------------
// add_pipe_n
//
// Pipelined WIDTH-bit adder/subtractor built from 4-bit ripple slices, one
// register stage per slice. Each pipeline stage carries the full operands
// forward (the input skew) and the nibbles already summed (the output
// deskew). All nibbles of one transaction therefore emerge together after
// STAGES cycles. A valid bit travels with every stage. A full output with
// no consumer stalls the whole pipe.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, clears every register
//   in_valid   operands presented this cycle
//   in_ready   block accepts operands this cycle (low only while stalled)
//   in_0       operand A
//   in_1       operand B
//   cin        carry-in (add) / borrow-in (subtract)
//   sub        0: A + B + cin, 1: A - B - cin
//   out_valid  result presented this cycle
//   out_ready  consumer accepts the result this cycle
//   out        sum / difference modulo 2^WIDTH
//   cout       carry out of the top bit (1 = no borrow when subtracting)
//   ovf        two's-complement signed overflow
// ---------------------------------------------------------------------------
module add_pipe_n #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / 4;

    // Stage s holds the transaction after slice s has been evaluated.
    logic             valid_q [STAGES];
    logic             valid_d [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic             ovf_q;
    logic             ovf_d;

    // Per-slice combinational result: {carry into bit 3, carry out, sum}.
    logic [5:0]       slice_res [STAGES];
    logic [WIDTH-1:0] b_cond;
    logic             c0;
    logic             stall;

    // 4-bit ripple slice. The carry into its top bit is returned as well so
    // the top slice can form the signed overflow flag.
    function automatic logic [5:0] slice_add(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic       ci);
        logic [3:0] low;
        logic [4:0] full;
        low  = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, ci};
        full = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        return {low[3], full};
    endfunction

    // A waiting result that nobody takes freezes the entire pipe.
    assign stall     = valid_q[STAGES-1] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = valid_q[STAGES-1];
    assign out       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q;

    // Subtraction is A + ~B + 1, with the borrow-in folded into the carry:
    // inverting cin turns "minus borrow" into "plus carry".
    always_comb begin
        b_cond       = in_1 ^ {WIDTH{sub}};
        c0           = cin ^ sub;
        slice_res[0] = slice_add(in_0[3:0], b_cond[3:0], c0);
        for (int s = 1; s < STAGES; s++) begin
            slice_res[s] = slice_add(a_q[s-1][4*s +: 4], b_q[s-1][4*s +: 4],
                                     carry_q[s-1]);
        end
    end

    // Next-state for every stage. Holding is the default, so a stall simply
    // skips the advance. A rejected or absent input enters as a bubble.
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            valid_d[s] = valid_q[s];
            carry_d[s] = carry_q[s];
            a_d[s]     = a_q[s];
            b_d[s]     = b_q[s];
            sum_d[s]   = sum_q[s];
        end
        ovf_d = ovf_q;

        if (!stall) begin
            valid_d[0]      = in_valid;
            a_d[0]          = in_0;
            b_d[0]          = b_cond;
            carry_d[0]      = slice_res[0][4];
            sum_d[0]        = '0;
            sum_d[0][3:0]   = slice_res[0][3:0];
            for (int s = 1; s < STAGES; s++) begin
                valid_d[s]          = valid_q[s-1];
                a_d[s]              = a_q[s-1];
                b_d[s]              = b_q[s-1];
                carry_d[s]          = slice_res[s][4];
                sum_d[s]            = sum_q[s-1];
                sum_d[s][4*s +: 4]  = slice_res[s][3:0];
            end
            ovf_d = slice_res[STAGES-1][5] ^ slice_res[STAGES-1][4];
        end
    end

    // Reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_q[s] <= 1'b0;
                carry_q[s] <= 1'b0;
                a_q[s]     <= '0;
                b_q[s]     <= '0;
                sum_q[s]   <= '0;
            end
            ovf_q <= 1'b0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                valid_q[s] <= valid_d[s];
                carry_q[s] <= carry_d[s];
                a_q[s]     <= a_d[s];
                b_q[s]     <= b_d[s];
                sum_q[s]   <= sum_d[s];
            end
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_add_pipe_n.sv
// ---------------------------------------------------------------------------
// tb_add_pipe_n
//
// Bench for add_pipe_n at WIDTH = 16 (latency 4). Accepted operands are
// turned into expected results by an integer-arithmetic model. Completed
// results are collected in a second queue, and each scenario task compares
// the two queues.
// ---------------------------------------------------------------------------
module tb_add_pipe_n;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_0;
    logic [WIDTH-1:0] in_1;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    // Entries are {ovf, cout, out}.
    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];

    add_pipe_n #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_0      (in_0),
        .in_1      (in_1),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    // Reference: plain unsigned and signed integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sb);
        int ua, ub, sa, sbv, c, r, sr;
        logic co, ov;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        c   = ci ? 1 : 0;
        if (sb) begin
            r  = ua - ub - c;
            sr = sa - sbv - c;
            co = (r >= 0);
        end else begin
            r  = ua + ub + c;
            sr = sa + sbv + c;
            co = (r > 65535);
        end
        ov = (sr > 32767) || (sr < -32768);
        return {ov, co, r[15:0]};
    endfunction

    // One clock cycle. Handshakes are observed at the falling edge, then the
    // task returns just after the rising edge so callers can drive again.
    task automatic tick();
        @(negedge clk);
        if (in_valid && in_ready) exp_q.push_back(model(in_0, in_1, cin, sub));
        if (out_valid && out_ready) got_q.push_back({ovf, cout, out});
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        in_0 = 16'($urandom);
        in_1 = 16'($urandom);
        cin  = 1'($urandom_range(0, 1));
        sub  = 1'($urandom_range(0, 1));
    endtask

    // Lets the pipe empty, with a bounded number of cycles.
    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (got_q.size() >= exp_q.size() && !out_valid) break;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_0 = '0; in_1 = '0; cin = 1'b0; sub = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_initial: out_valid=%b in_ready=%b out=%h cout=%b ovf=%b, required 0 1 0000 0 0",
                     out_valid, in_ready, out, cout, ovf);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Three transactions in flight, then reset between edges.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_0 = 16'h1111 * 16'(i + 1); in_1 = 16'h0101; cin = 1'b0; sub = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out !== 16'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_midstream: out_valid=%b out=%h in_ready=%b, required 0 0000 1",
                     out_valid, out, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL reset_discard: %0d stale results appeared, required 0", got_q.size());
        end
        got_q.delete();
    endtask

    task automatic test_directed();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic        vc [4];
        logic        vs [4];
        logic [17:0] vexp [4];
        va[0] = 16'hFFFF; vb[0] = 16'h0001; vc[0] = 1'b0; vs[0] = 1'b0; vexp[0] = {1'b0, 1'b1, 16'h0000};
        va[1] = 16'h7FFF; vb[1] = 16'h0000; vc[1] = 1'b1; vs[1] = 1'b0; vexp[1] = {1'b1, 1'b0, 16'h8000};
        va[2] = 16'h0005; vb[2] = 16'h0007; vc[2] = 1'b0; vs[2] = 1'b1; vexp[2] = {1'b0, 1'b0, 16'hFFFE};
        va[3] = 16'h8000; vb[3] = 16'h0001; vc[3] = 1'b0; vs[3] = 1'b1; vexp[3] = {1'b1, 1'b1, 16'h7FFF};
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            in_valid = 1'b1;
            in_0 = va[v]; in_1 = vb[v]; cin = vc[v]; sub = vs[v];
            tick();
            in_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL latency_early vec%0d cycle%0d: out_valid=%b, required 0", v, i + 1, out_valid);
                end
                tick();
            end
            checks++;
            if (out_valid !== 1'b1 || {ovf, cout, out} !== vexp[v]) begin
                errors++;
                $display("[TB] FAIL directed vec%0d: valid=%b ovf=%b cout=%b out=%h, required 1 %b %b %h",
                         v, out_valid, ovf, cout, out, vexp[v][17], vexp[v][16], vexp[v][15:0]);
            end
            tick();
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            applyStimulus();
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stream_ready i=%0d: in_ready=%b, required 1", i, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (got_q.size() != 100 || exp_q.size() != 100) begin
            errors++;
            $display("[TB] FAIL stream_count: got=%0d accepted=%0d after 104 cycles, required 100 100",
                     got_q.size(), exp_q.size());
        end
        drain();
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL stream_result #%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            tick();
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_valid: out_valid=%b, required 1", out_valid);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_in_ready cycle%0d: in_ready=%b, required 0", i, in_ready);
            end
            checks++;
            if (got_q.size() >= exp_q.size()) begin
                errors++;
                $display("[TB] FAIL bp_head cycle%0d: no pending result, got=%0d accepted=%0d",
                         i, got_q.size(), exp_q.size());
            end else if (out_valid !== 1'b1 || {ovf, cout, out} !== exp_q[got_q.size()]) begin
                errors++;
                $display("[TB] FAIL bp_hold cycle%0d: valid=%b result=%h, required 1 %h",
                         i, out_valid, {ovf, cout, out}, exp_q[got_q.size()]);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            tick();
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL bp_count: got=%0d, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL bp_result #%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_sparse();
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            applyStimulus();
            tick();
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL sparse_count: got=%0d, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL sparse_result #%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_streaming();
        test_backpressure();
        test_sparse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
